// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS32 core.
// Forwards EX results to MEM and loops the madd/msub partial product back to EX during a stall.
module ex_mem_reg #(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic                 ex_whilo,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic                 mem_whilo,
  output logic                 mem_valid,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [1:0]           cnt_o
);

  localparam int EX_BIT  = 3;
  localparam int MEM_BIT = 4;

  logic advance;
  logic bubble;
  logic unused_stall;

  // The illegal "MEM stalled, EX running" vector falls into advance on purpose.
  assign advance      = !stall[EX_BIT];
  assign bubble       = stall[EX_BIT] && !stall[MEM_BIT];
  assign unused_stall = ^{stall[STALL_W-1:MEM_BIT+1], stall[EX_BIT-1:0]};

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= 2'b00;
    end else if (advance) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      mem_valid <= 1'b1;
      hilo_o    <= '0;
      cnt_o     <= 2'b00;
    end else if (bubble) begin
      // MEM gets a bubble while EX keeps its first-cycle partial product.
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: constant vector table, directed corner sequences and
// randomized cycles checked against a transaction-level model.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } in_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        valid;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [5:0] ST0 = 6'b000000;
  localparam logic [5:0] BUB = 6'b001111;
  localparam logic [5:0] HLD = 6'b011111;
  localparam int NVEC = 20;

  logic clk;
  in_t  cur;
  out_t act;
  out_t mdl;
  int   checks;
  int   failures;
  vec_t tbl [NVEC];

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        mem_valid;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  ex_mem_reg #(.REG_W(32), .ADDR_W(5), .STALL_W(6)) dut (
    .clk       (clk),
    .rst       (cur.rst),
    .stall     (cur.stall),
    .flush     (cur.flush),
    .ex_wd     (cur.wd),
    .ex_wreg   (cur.wreg),
    .ex_wdata  (cur.wdata),
    .ex_hi     (cur.hi),
    .ex_lo     (cur.lo),
    .ex_whilo  (cur.whilo),
    .hilo_i    (cur.hilo),
    .cnt_i     (cur.cnt),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .mem_valid (mem_valid),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (cur.rst && cur.stall[4] && !cur.stall[3])
      $warning("illegal stall vector %b (MEM stalled, EX running)", cur.stall);
  end

  function automatic in_t mk_in(logic r, logic [5:0] s, logic f, logic [4:0] wd, logic wreg,
                                logic [31:0] wdata, logic [31:0] hi, logic [31:0] lo,
                                logic whilo, logic [63:0] hilo, logic [1:0] cnt);
    return '{r, s, f, wd, wreg, wdata, hi, lo, whilo, hilo, cnt};
  endfunction

  function automatic out_t mk_out(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                  logic [31:0] hi, logic [31:0] lo, logic whilo,
                                  logic valid, logic [63:0] hilo, logic [1:0] cnt);
    return '{wd, wreg, wdata, hi, lo, whilo, valid, hilo, cnt};
  endfunction

  // Transaction-level rules: what the MEM slot and the EX loop-back hold after one edge.
  function automatic out_t model_next(out_t s, in_t x);
    out_t n;
    n = s;
    if (!x.rst || x.flush)
      n = '0;
    else if (!x.stall[3])
      n = mk_out(x.wd, x.wreg, x.wdata, x.hi, x.lo, x.whilo, 1'b1, 64'd0, 2'd0);
    else if (!x.stall[4])
      n = mk_out(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, x.hilo, x.cnt);
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    logic [6:0] sv;
    int k;
    k = $urandom_range(0, 6);
    sv = (7'd1 << k) - 7'd1;
    x.rst   = ($urandom_range(0, 19) != 0);
    x.flush = ($urandom_range(0, 15) == 0);
    x.stall = sv[5:0];
    x.wd    = 5'($urandom);
    x.wreg  = 1'($urandom);
    x.wdata = $urandom;
    x.hi    = $urandom;
    x.lo    = $urandom;
    x.whilo = 1'($urandom);
    x.hilo  = {$urandom, $urandom};
    x.cnt   = 2'($urandom);
    return x;
  endfunction

  task automatic check(string name, out_t exp);
    act = mk_out(mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_valid, hilo_o, cnt_o);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run(in_t x, out_t exp, string name);
    cur = x;
    mdl = model_next(mdl, x);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    in_t  x;
    out_t held;
    checks   = 0;
    failures = 0;
    mdl      = '0;

    tbl[0]  = '{mk_in(0, ST0, 0, 5'd9, 1, 32'hAAAA0000, 32'd1, 32'd2, 1, 64'h55, 2'd1), '0};
    tbl[1]  = '{mk_in(0, ST0, 0, 5'd9, 1, 32'hAAAA0000, 32'd1, 32'd2, 1, 64'h55, 2'd1), '0};
    tbl[2]  = '{mk_in(1, ST0, 0, 5'd3, 1, 32'hDEADBEEF, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd3, 1, 32'hDEADBEEF, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[3]  = '{mk_in(1, ST0, 0, 5'd4, 1, 32'h11111111, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd4, 1, 32'h11111111, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[4]  = '{mk_in(1, ST0, 0, 5'd5, 1, 32'h22222222, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd5, 1, 32'h22222222, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[5]  = '{mk_in(1, ST0, 0, 5'd6, 1, 32'h33333333, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd6, 1, 32'h33333333, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[6]  = '{mk_in(1, ST0, 0, 5'd7, 0, 32'h44444444, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd7, 0, 32'h44444444, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[7]  = '{mk_in(1, BUB, 0, 5'd8, 1, 32'h55555555, 32'd0, 32'd0, 1, 64'h0000_0001_FFFF_FFFE, 2'd1),
                mk_out(5'd0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 64'h0000_0001_FFFF_FFFE, 2'd1)};
    tbl[8]  = '{mk_in(1, ST0, 0, 5'd9, 0, 32'd0, 32'd1, 32'd5, 1, 64'hFFFF, 2'd2),
                mk_out(5'd9, 0, 32'd0, 32'd1, 32'd5, 1, 1, 64'd0, 2'd0)};
    tbl[9]  = '{mk_in(1, ST0, 0, 5'd10, 1, 32'h12345678, 32'd0, 32'd0, 0, 64'd0, 2'd0),
                mk_out(5'd10, 1, 32'h12345678, 32'd0, 32'd0, 0, 1, 64'd0, 2'd0)};
    tbl[10] = '{mk_in(1, HLD, 0, 5'd31, 0, 32'hFFFFFFFF, 32'h1, 32'h2, 1, 64'h77, 2'd3), tbl[9].o};
    tbl[11] = '{mk_in(1, HLD, 0, 5'd1, 1, 32'h0, 32'h3, 32'h4, 0, 64'h88, 2'd1), tbl[9].o};
    tbl[12] = '{mk_in(1, HLD, 0, 5'd2, 0, 32'hA5A5A5A5, 32'h5, 32'h6, 1, 64'h99, 2'd2), tbl[9].o};
    tbl[13] = '{mk_in(1, BUB, 0, 5'd3, 1, 32'h1, 32'h1, 32'h1, 1, 64'h1234_5678_9ABC_DEF0, 2'd1),
                mk_out(5'd0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 64'h1234_5678_9ABC_DEF0, 2'd1)};
    tbl[14] = '{mk_in(1, BUB, 1, 5'd1, 1, 32'h1, 32'h1, 32'h1, 1, 64'hCAFE, 2'd1), '0};
    tbl[15] = '{mk_in(1, BUB, 0, 5'd4, 1, 32'h9, 32'h9, 32'h9, 1, 64'h0000_0002_0000_0003, 2'd1),
                mk_out(5'd0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 64'h0000_0002_0000_0003, 2'd1)};
    tbl[16] = '{mk_in(1, HLD, 0, 5'd4, 1, 32'h9, 32'h9, 32'h9, 1, 64'hBEEF, 2'd2), tbl[15].o};
    tbl[17] = '{mk_in(0, BUB, 0, 5'd4, 1, 32'h9, 32'h9, 32'h9, 1, 64'hBEEF, 2'd1), '0};
    tbl[18] = '{mk_in(1, ST0, 0, 5'd17, 1, 32'h0BADF00D, 32'd7, 32'd8, 1, 64'h99, 2'd3),
                mk_out(5'd17, 1, 32'h0BADF00D, 32'd7, 32'd8, 1, 1, 64'd0, 2'd0)};
    tbl[19] = '{mk_in(1, ST0, 1, 5'd20, 1, 32'h1, 32'h2, 32'h3, 1, 64'h4, 2'd1), '0};

    for (int i = 0; i < NVEC; i++)
      run(tbl[i].i, tbl[i].o, $sformatf("vec%0d", i));

    // Hold with random EX traffic after loading a known word.
    x = mk_in(1, ST0, 0, 5'd12, 1, 32'h12345678, 32'hAB, 32'hCD, 1, 64'd0, 2'd0);
    held = mk_out(5'd12, 1, 32'h12345678, 32'hAB, 32'hCD, 1, 1, 64'd0, 2'd0);
    run(x, held, "hold_load");
    for (int i = 0; i < 3; i++) begin
      x = rand_in();
      x.rst = 1'b1;
      x.flush = 1'b0;
      x.stall = HLD;
      run(x, held, $sformatf("hold_rand%0d", i));
      checks++;
      if (mem_wdata !== 32'h12345678) begin
        failures++;
        $display("FAIL hold_wdata%0d got=%h exp=12345678", i, mem_wdata);
      end
    end

    // Illegal vector: MEM stalled while EX runs still advances.
    x = mk_in(1, 6'b010000, 0, 5'd21, 1, 32'hFEEDFACE, 32'd2, 32'd3, 0, 64'h5, 2'd1);
    run(x, mk_out(5'd21, 1, 32'hFEEDFACE, 32'd2, 32'd3, 0, 1, 64'd0, 2'd0), "illegal_stall");

    for (int i = 0; i < 400; i++) begin
      x = rand_in();
      run(x, model_next(mdl, x), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
